// File: rtl/shift_seq_pkg.sv
// rtl/shift_seq_pkg.sv - shared types, default constants and width helper for the shift sequencer
package shift_seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        WAIT = 3'd2,
        STEP = 3'd3,
        CAPT = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam int PAT_W_DEF      = 8;
    localparam int DEB_CYCLES_DEF = 1000000;
    localparam int AUTO_DIV_DEF   = 50000000;

    // Width able to hold the value n itself (bit_cnt reaches PAT_W).
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - synchroniser plus stability counter for one push-button
module btn_debounce #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic cp,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic rise_p
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Two-flop synchroniser: the raw button is asynchronous to cp.
    always_ff @(posedge cp) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after an unbroken run of differing samples; one agreeing sample restarts the run.
    always_ff @(posedge cp) begin
        if (rst) begin
            cnt    <= '0;
            level  <= 1'b0;
            rise_p <= 1'b0;
        end else begin
            rise_p <= 1'b0;
            if (sync2 != level) begin
                if (cnt == CNT_LAST) begin
                    level  <= sync2;
                    cnt    <= '0;
                    rise_p <= sync2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - serial pattern stepper driving the shift/parity datapath and recording z
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int PAT_W      = PAT_W_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int AUTO_DIV   = AUTO_DIV_DEF
) (
    input  logic                      cp,
    input  logic                      rst,
    input  logic                      btn_start,
    input  logic                      btn_step,
    input  logic                      auto_mode,
    input  logic [PAT_W-1:0]          pattern,
    input  logic                      z_in,
    output logic                      step_en,
    output logic                      x_out,
    output logic [cnt_w(PAT_W)-1:0]   bit_cnt,
    output logic                      busy,
    output logic                      done,
    output logic [PAT_W-1:0]          z_hist
);

    localparam int CW = cnt_w(PAT_W);
    localparam int TW = $clog2(AUTO_DIV + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(PAT_W - 1);
    localparam logic [TW-1:0] TICK_AT  = TW'(AUTO_DIV - 1);

    state_t           state;
    state_t           state_nxt;
    logic [PAT_W-1:0] shreg;
    logic [TW-1:0]    timer;
    logic             start_p;
    logic             step_p;
    logic             tick;
    logic             trig;
    logic             start_lvl_unused;
    logic             step_lvl_unused;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
        .cp      (cp),
        .rst     (rst),
        .btn_raw (btn_start),
        .level   (start_lvl_unused),
        .rise_p  (start_p)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
        .cp      (cp),
        .rst     (rst),
        .btn_raw (btn_step),
        .level   (step_lvl_unused),
        .rise_p  (step_p)
    );

    // Auto-step timer: zero on every WAIT entry, saturates so a late switch to auto steps at once.
    always_ff @(posedge cp) begin
        if (rst || state != WAIT) begin
            timer <= '0;
        end else if (timer != TICK_AT) begin
            timer <= timer + 1'b1;
        end
    end

    assign tick = (state == WAIT) && (timer == TICK_AT);
    assign trig = auto_mode ? tick : step_p;

    // State register.
    always_ff @(posedge cp) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; trig and start_p are only honoured in the states that wait for them.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_p) state_nxt = LOAD;
            LOAD:    state_nxt = WAIT;
            WAIT:    if (trig) state_nxt = STEP;
            STEP:    state_nxt = CAPT;
            CAPT:    state_nxt = (bit_cnt == LAST_BIT) ? DONE : WAIT;
            DONE:    if (start_p) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from state; x_out holds the current bit across WAIT and STEP.
    always_comb begin
        step_en = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        x_out   = 1'b0;
        case (state)
            LOAD: busy = 1'b1;
            WAIT: begin
                busy  = 1'b1;
                x_out = shreg[PAT_W-1];
            end
            STEP: begin
                busy    = 1'b1;
                step_en = 1'b1;
                x_out   = shreg[PAT_W-1];
            end
            CAPT: busy = 1'b1;
            DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Pattern shifter, step counter and z capture; z is taken in CAPT, after the datapath has updated.
    always_ff @(posedge cp) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
            z_hist  <= '0;
        end else begin
            case (state)
                LOAD: begin
                    shreg   <= pattern;
                    bit_cnt <= '0;
                    z_hist  <= '0;
                end
                CAPT: begin
                    shreg   <= shreg << 1;
                    bit_cnt <= bit_cnt + 1'b1;
                    z_hist  <= {z_hist[PAT_W-2:0], z_in};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - directed table-driven bench for shift_seq_ctrl
module tb_shift_seq_ctrl;

    logic       cp = 1'b0;
    logic       rst = 1'b1;
    logic       btn_start = 1'b1;
    logic       btn_step = 1'b1;
    logic       auto_mode = 1'b0;
    logic [7:0] pattern = 8'h00;
    logic       z_in = 1'b0;
    logic       step_en;
    logic       x_out;
    logic [3:0] bit_cnt;
    logic       busy;
    logic       done;
    logic [7:0] z_hist;

    shift_seq_ctrl #(.PAT_W(8), .DEB_CYCLES(4), .AUTO_DIV(10)) dut (
        .cp        (cp),
        .rst       (rst),
        .btn_start (btn_start),
        .btn_step  (btn_step),
        .auto_mode (auto_mode),
        .pattern   (pattern),
        .z_in      (z_in),
        .step_en   (step_en),
        .x_out     (x_out),
        .bit_cnt   (bit_cnt),
        .busy      (busy),
        .done      (done),
        .z_hist    (z_hist)
    );

    always #5 cp = ~cp;

    typedef struct {
        logic [7:0] pat;
        logic [7:0] zv;
        logic [7:0] exp_x;
        logic [7:0] exp_zh;
    } vec_t;

    vec_t       tbl[3];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         n_steps = 0;
    int         load_cyc = -1;
    int         done_cyc = -1;
    int         step_cyc[$];
    logic [7:0] xseq = 8'h00;
    logic [7:0] zvec_cur = 8'h00;
    logic       busy_prev = 1'b0;
    logic       done_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge cp);
        cyc++;
        @(negedge cp);
        if (step_en === 1'b1) begin
            xseq = {xseq[6:0], x_out};
            n_steps++;
            step_cyc.push_back(cyc);
            if (n_steps >= 1 && n_steps <= 8) z_in = zvec_cur[3'(8 - n_steps)];
        end
        if (busy === 1'b1 && busy_prev !== 1'b1) load_cyc = cyc;
        if (done === 1'b1 && done_prev !== 1'b1) done_cyc = cyc;
        busy_prev = busy;
        done_prev = done;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input logic s, input logic t, input int hi);
        btn_start = s;
        btn_step  = t;
        ticks(hi);
        btn_start = 1'b0;
        btn_step  = 1'b0;
        ticks(8);
    endtask

    task automatic new_run(input logic [7:0] pat, input logic [7:0] zv);
        pattern  = pat;
        zvec_cur = zv;
        n_steps  = 0;
        xseq     = 8'h00;
        load_cyc = -1;
        done_cyc = -1;
        step_cyc.delete();
    endtask

    initial begin
        tbl[0] = '{8'hB2, 8'hAA, 8'b10110010, 8'hAA};
        tbl[1] = '{8'h5C, 8'h0F, 8'b01011100, 8'h0F};
        tbl[2] = '{8'h81, 8'hC3, 8'b10000001, 8'hC3};

        // Reset with both buttons held.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_step_en", 32'(step_en), 32'd0);
        end
        chk("rst_x_out", 32'(x_out), 32'd0);
        chk("rst_bit_cnt", 32'(bit_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_z_hist", 32'(z_hist), 32'd0);
        rst = 1'b0;
        btn_start = 1'b0;
        btn_step = 1'b0;
        ticks(12);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_done", 32'(done), 32'd0);
        chk("post_rst_steps", 32'(n_steps), 32'd0);

        // Manual runs from the table; runs after the first restart from DONE.
        for (int i = 0; i < 3; i++) begin
            new_run(tbl[i].pat, tbl[i].zv);
            press(1'b1, 1'b0, 8);
            chk("tbl_load_busy", 32'(busy), 32'd1);
            chk("tbl_load_cnt", 32'(bit_cnt), 32'd0);
            chk("tbl_load_zh", 32'(z_hist), 32'd0);
            chk("tbl_load_done", 32'(done), 32'd0);
            for (int k = 0; k < 8; k++) press(1'b0, 1'b1, 8);
            ticks(2);
            chk("tbl_steps", 32'(n_steps), 32'd8);
            chk("tbl_xseq", 32'(xseq), 32'(tbl[i].exp_x));
            chk("tbl_z_hist", 32'(z_hist), 32'(tbl[i].exp_zh));
            chk("tbl_done", 32'(done), 32'd1);
            chk("tbl_busy", 32'(busy), 32'd0);
            chk("tbl_bit_cnt", 32'(bit_cnt), 32'd8);
            chk("tbl_x_idle", 32'(x_out), 32'd0);
        end

        // Debounce: short glitch, then bounce followed by a stable press.
        new_run(8'hB2, 8'h00);
        press(1'b1, 1'b0, 8);
        btn_step = 1'b1; ticks(3);
        btn_step = 1'b0; ticks(12);
        chk("glitch_steps", 32'(n_steps), 32'd0);
        chk("glitch_busy", 32'(busy), 32'd1);
        btn_step = 1'b1; ticks(1);
        btn_step = 1'b0; ticks(1);
        btn_step = 1'b1; ticks(7);
        btn_step = 1'b0; ticks(10);
        chk("bounce_steps", 32'(n_steps), 32'd1);
        chk("bounce_cnt", 32'(bit_cnt), 32'd1);
        for (int k = 0; k < 7; k++) press(1'b0, 1'b1, 8);
        ticks(2);
        chk("deb_xseq", 32'(xseq), 32'hB2);
        chk("deb_done", 32'(done), 32'd1);
        btn_step = 1'b1; ticks(20);
        chk("held_steps", 32'(n_steps), 32'd8);
        chk("held_cnt", 32'(bit_cnt), 32'd8);
        chk("held_done", 32'(done), 32'd1);
        btn_step = 1'b0; ticks(10);

        // Start and step together in DONE: start wins, step is not queued.
        new_run(8'hB2, 8'hE0);
        press(1'b1, 1'b1, 8);
        ticks(4);
        chk("both_busy", 32'(busy), 32'd1);
        chk("both_steps", 32'(n_steps), 32'd0);
        chk("both_cnt", 32'(bit_cnt), 32'd0);
        chk("both_done", 32'(done), 32'd0);

        // Reset after three steps discards the partial capture.
        for (int k = 0; k < 3; k++) press(1'b0, 1'b1, 8);
        chk("mid_cnt", 32'(bit_cnt), 32'd3);
        chk("mid_zh", 32'(z_hist), 32'h07);
        rst = 1'b1;
        ticks(2);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_cnt", 32'(bit_cnt), 32'd0);
        chk("mrst_zh", 32'(z_hist), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_x", 32'(x_out), 32'd0);
        chk("mrst_step_en", 32'(step_en), 32'd0);
        rst = 1'b0;
        ticks(4);
        chk("mrst_idle", 32'(busy), 32'd0);

        // Restart with 8'h01; pattern changes and start presses mid-run are ignored.
        new_run(8'h01, 8'h00);
        press(1'b1, 1'b0, 8);
        pattern = 8'hFF;
        press(1'b0, 1'b1, 8);
        press(1'b0, 1'b1, 8);
        chk("rs_cnt2", 32'(bit_cnt), 32'd2);
        press(1'b1, 1'b0, 8);
        chk("rs_start_ign_cnt", 32'(bit_cnt), 32'd2);
        chk("rs_start_ign_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 6; k++) press(1'b0, 1'b1, 8);
        ticks(2);
        chk("rs_xseq", 32'(xseq), 32'h01);
        chk("rs_steps", 32'(n_steps), 32'd8);
        chk("rs_done", 32'(done), 32'd1);
        chk("rs_cnt", 32'(bit_cnt), 32'd8);

        // Auto mode with step presses thrown in.
        auto_mode = 1'b1;
        new_run(8'hFF, 8'h55);
        press(1'b1, 1'b0, 8);
        for (int k = 0; k < 300 && done !== 1'b1; k++) begin
            btn_step = ((k / 8) % 2 == 0);
            tick();
        end
        btn_step = 1'b0;
        chk("auto_done", 32'(done), 32'd1);
        chk("auto_nsteps", 32'(step_cyc.size()), 32'd8);
        if (step_cyc.size() == 8) begin
            chk("auto_first", 32'(step_cyc[0] - load_cyc), 32'd11);
            for (int k = 1; k < 8; k++)
                chk("auto_period", 32'(step_cyc[k] - step_cyc[k-1]), 32'd12);
            chk("auto_done_lat", 32'(done_cyc - step_cyc[7]), 32'd2);
        end
        chk("auto_xseq", 32'(xseq), 32'hFF);
        chk("auto_zh", 32'(z_hist), 32'h55);
        chk("auto_cnt", 32'(bit_cnt), 32'd8);
        auto_mode = 1'b0;
        ticks(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
